// File: rtl/mult_arbiter_if.sv
// Request/operand/result bundle between four requesters and the shared-multiplier arbiter.
interface mult_arbiter_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic [15:0]      a_in;
    logic [15:0]      b_in;
    logic [3:0]       gnt;
    logic [3:0]       done;
    logic [7:0]       product;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, product, busy, op_count
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, product, busy, op_count
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational 4x4 multiplier among four requesters.
module multiplier_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'b0000, a} * {4'b0000, b};
endmodule

// state | meaning
// IDLE  | no operation in flight; grant the round-robin winner when any req is set
// CALC  | operands latched; multiplier output captured into product on next edge
// RESP  | done/gnt held for the winner until it drops its request
module mult_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    mult_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       gnt, gnt_nxt;
    logic [3:0]       done, done_nxt;
    logic [3:0]       opa, opa_nxt;
    logic [3:0]       opb, opb_nxt;
    logic [7:0]       product, product_nxt;
    logic [7:0]       mult_p;
    logic [CNT_W-1:0] op_count, op_count_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       sel, sel_nxt;
    logic [1:0]       win;
    logic             found;

    multiplier_4x4 u_mult (
        .a (opa),
        .b (opb),
        .p (mult_p)
    );

    // Search starts at ptr and wraps naturally through the 2-bit index.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && bus.req[ptr + 2'(k)]) begin
                win   = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        done_nxt     = done;
        opa_nxt      = opa;
        opb_nxt      = opb;
        product_nxt  = product;
        op_count_nxt = op_count;
        ptr_nxt      = ptr;
        sel_nxt      = sel;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = 4'b0001 << win;
                    sel_nxt   = win;
                    opa_nxt   = bus.a_in[{win, 2'b00} +: 4];
                    opb_nxt   = bus.b_in[{win, 2'b00} +: 4];
                    state_nxt = CALC;
                end
            end
            CALC: begin
                product_nxt  = mult_p;
                done_nxt     = gnt;
                op_count_nxt = op_count + CNT_W'(1);
                state_nxt    = RESP;
            end
            RESP: begin
                if (!bus.req[sel]) begin
                    gnt_nxt   = 4'b0000;
                    done_nxt  = 4'b0000;
                    ptr_nxt   = sel + 2'd1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = 4'b0000;
                done_nxt  = 4'b0000;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            done     <= 4'b0000;
            opa      <= 4'h0;
            opb      <= 4'h0;
            product  <= 8'h00;
            op_count <= '0;
            ptr      <= 2'd0;
            sel      <= 2'd0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            opa      <= opa_nxt;
            opb      <= opb_nxt;
            product  <= product_nxt;
            op_count <= op_count_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.done     = done;
    assign bus.product  = product;
    assign bus.busy     = (state != IDLE);
    assign bus.op_count = op_count;
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: MULT_ARBITER

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-operation counter OP_COUNT.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ  input  4  per-requester request level; bit i is held by requester i until it sees DONE[i].
REQ-005 A_IN  input  16  packed multiplicands; requester i drives A_IN[4i+3:4i].
REQ-006 B_IN  input  16  packed multipliers; requester i drives B_IN[4i+3:4i].
REQ-007 GNT  output  4  one-hot grant, all-zero when idle; registered.
REQ-008 DONE  output  4  one-hot result-valid for the granted requester; registered.
REQ-009 PRODUCT  output  8  unsigned product of the last completed operation; registered.
REQ-010 BUSY  output  1  high whenever the FSM state is not IDLE; registered/state-decoded.
REQ-011 OP_COUNT  output  CNT_W  count of completed operations; registered.

Function
REQ-012 The block SHALL share exactly one instance of the team's combinational 4x4 multiplier MULTIPLIER_4X4 among 4 requesters.
REQ-013 FSM states SHALL be IDLE, CALC and RESP only; no other state is reachable.
REQ-014 IDLE: at a clock edge with REQ != 0, the block SHALL pick winner g by round-robin, set GNT[g], latch A_IN/B_IN slice g into operand registers, and go to CALC.
REQ-015 Round-robin: search order starts at pointer PTR and proceeds PTR, PTR+1, ... mod 4; the first set REQ bit wins.
REQ-016 IDLE with REQ == 0: state, GNT, DONE, PTR and PRODUCT SHALL hold.
REQ-017 CALC: at the next edge, the block SHALL register the multiplier output of the latched operands into PRODUCT, set DONE[g], increment OP_COUNT, and go to RESP.
REQ-018 Latency: GNT[g] is visible 1 edge after REQ[g] is sampled; DONE[g] and PRODUCT are visible 2 edges after.
REQ-019 Operand changes on A_IN/B_IN after the grant edge SHALL NOT affect the result.
REQ-020 RESP: GNT[g] and DONE[g] SHALL stay high until an edge samples REQ[g]==0.
REQ-021 On that edge, the block SHALL clear GNT and DONE, set PTR=(g+1) mod 4, and go to IDLE; a new grant is possible no earlier than the following edge (minimum 3 cycles per operation plus the release cycle).
REQ-022 If REQ[g] drops during CALC, the operation SHALL still complete; RESP then lasts exactly one cycle.
REQ-023 Requests from other requesters during CALC/RESP SHALL be ignored until IDLE; they are not lost because REQ is level.
REQ-024 PRODUCT SHALL hold its value until the next completion; it SHALL be exact for all 256 operand pairs (max 15*15=225=0xE1).
REQ-025 OP_COUNT SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-026 GNT and DONE SHALL each be one-hot or zero at all times, and DONE SHALL be nonzero only in RESP.

Reset
REQ-027 RST high SHALL immediately force state=IDLE, GNT=0, DONE=0, PRODUCT=0x00, BUSY=0, OP_COUNT=0, PTR=0 and operand registers=0, independent of CLK.
REQ-028 RST asserted mid-CALC or mid-RESP SHALL abort the operation without a completion and without incrementing OP_COUNT.
REQ-029 After RST deasserts, the first edge SHALL behave as IDLE with PTR=0.

Verification
REQ-030 Single request: REQ=0001, A=4'hF, B=4'hF -> GNT=0001 after edge 1; DONE=0001 and PRODUCT=0xE1 after edge 2; OP_COUNT=1; release REQ -> IDLE.
REQ-031 Fairness: REQ=1111 held, each requester releasing 1 cycle after its DONE -> grant order 0,1,2,3,0; no requester is granted twice before all have been served.
REQ-032 Operand stability: requester 2 with A=3, B=5 granted, then A_IN slice changed to 0xF during CALC -> PRODUCT=0x0F (15).
REQ-033 Early release: REQ[1] dropped in CALC -> DONE[1] high exactly 1 cycle and correct product.
REQ-034 Reset abort: RST pulsed while in RESP with DONE=0100 -> all outputs 0 asynchronously; next REQ=1100 grants requester 2 (PTR=0 search order 0,1,2).
REQ-035 Exhaustive/wrap: all 256 A,B pairs on requester 3 -> every PRODUCT matches A*B; OP_COUNT wraps to 0 after 256 operations.
